id_stage: RTL and testbench

- Decode stage of the 5-stage in-order RV32I pipeline, directly downstream of the fetch stage.
- Latches the fetch-stage outputs into the IF/ID pipeline register.
- Holds the 32x32 architectural register file, written from write-back.
- Reads rs1/rs2 operands, generates the sign-extended immediate, and exports the destination register used by the fetch-stage RAW hazard detector.

---
 rtl/id_stage_if.sv | 36 +++
 rtl/id_stage.sv | 115 +++++++++++
 tb/tb_id_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Signal bundle between fetch/write-back and the RV32I decode stage.
// The master side drives fetch and write-back inputs and observes the decode outputs.
interface id_stage_if;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_IR_out;
  logic        if_valid_inst_out;
  logic        ex_take_branch_out;
  logic        wb_reg_wr_en;
  logic [4:0]  wb_reg_wr_idx;
  logic [31:0] wb_reg_wr_data;
  logic [31:0] id_PC_out;
  logic [31:0] id_NPC_out;
  logic [31:0] id_IR_out;
  logic        id_valid_inst_out;
  logic [31:0] id_rs1_value;
  logic [31:0] id_rs2_value;
  logic [31:0] id_imm;
  logic [4:0]  id_rd;
  logic        id_reg_wr_en;
  logic        id_illegal;

  modport master (
    output if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out, ex_take_branch_out,
    output wb_reg_wr_en, wb_reg_wr_idx, wb_reg_wr_data,
    input  id_PC_out, id_NPC_out, id_IR_out, id_valid_inst_out,
    input  id_rs1_value, id_rs2_value, id_imm, id_rd, id_reg_wr_en, id_illegal
  );

  modport slave (
    input  if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out, ex_take_branch_out,
    input  wb_reg_wr_en, wb_reg_wr_idx, wb_reg_wr_data,
    output id_PC_out, id_NPC_out, id_IR_out, id_valid_inst_out,
    output id_rs1_value, id_rs2_value, id_imm, id_rd, id_reg_wr_en, id_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32x32 register file with
// write-first bypass, immediate generation and destination/illegal decode.
module id_stage #(
  parameter logic [31:0] NOOP_INST = 32'h00000013
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_LD    = 7'b0000011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  logic [31:0]       pc_d, pc_q;
  logic [31:0]       npc_d, npc_q;
  logic [31:0]       ir_d, ir_q;
  logic              valid_d, valid_q;
  logic [31:0][31:0] rf_d, rf_q;

  logic [6:0]  opcode;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        known_op, writes_rd;
  logic [31:0] rs1_val, rs2_val;

  function automatic logic [31:0] gen_imm(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OP_I_ARITH, OP_I_LD, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OP_S:                         imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_B:                         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:             imm = {ir[31:12], 12'b0};
      OP_JAL:                       imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                      imm = 32'b0;
    endcase
    return imm;
  endfunction

  // A taken branch squashes the incoming instruction but PC/NPC still advance.
  always_comb begin
    pc_d    = bus.if_PC_out;
    npc_d   = bus.if_NPC_out;
    ir_d    = bus.if_IR_out;
    valid_d = bus.if_valid_inst_out;
    if (bus.ex_take_branch_out) begin
      ir_d    = NOOP_INST;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (bus.wb_reg_wr_en && bus.wb_reg_wr_idx != 5'd0)
      rf_d[bus.wb_reg_wr_idx] = bus.wb_reg_wr_data;
  end

  // IF/ID register and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'b0;
      npc_q   <= 32'b0;
      ir_q    <= NOOP_INST;
      valid_q <= 1'b0;
      rf_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      rf_q    <= rf_d;
    end
  end

  assign opcode  = ir_q[6:0];
  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];

  // Write-first: a same-cycle write-back to a source register is forwarded.
  always_comb begin
    rs1_val = rf_q[rs1_idx];
    rs2_val = rf_q[rs2_idx];
    if (bus.wb_reg_wr_en && bus.wb_reg_wr_idx == rs1_idx) rs1_val = bus.wb_reg_wr_data;
    if (bus.wb_reg_wr_en && bus.wb_reg_wr_idx == rs2_idx) rs2_val = bus.wb_reg_wr_data;
    if (rs1_idx == 5'd0) rs1_val = 32'b0;
    if (rs2_idx == 5'd0) rs2_val = 32'b0;
  end

  always_comb begin
    known_op  = 1'b1;
    writes_rd = 1'b0;
    case (opcode)
      OP_R, OP_I_ARITH, OP_I_LD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_S, OP_B:                                                   writes_rd = 1'b0;
      default:                                                      known_op  = 1'b0;
    endcase
  end

  assign bus.id_PC_out         = pc_q;
  assign bus.id_NPC_out        = npc_q;
  assign bus.id_IR_out         = ir_q;
  assign bus.id_valid_inst_out = valid_q;
  assign bus.id_rs1_value      = rs1_val;
  assign bus.id_rs2_value      = rs2_val;
  assign bus.id_imm            = gen_imm(ir_q);
  assign bus.id_rd             = (valid_q && writes_rd) ? ir_q[11:7] : 5'd0;
  assign bus.id_reg_wr_en      = (bus.id_rd != 5'd0);
  assign bus.id_illegal        = valid_q && !known_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, register file, bypass, flush,
// immediate decode and illegal-opcode detection.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ir, input logic vld);
    bus.if_PC_out         = pc;
    bus.if_NPC_out        = pc + 32'd4;
    bus.if_IR_out         = ir;
    bus.if_valid_inst_out = vld;
  endtask

  task automatic wb(input logic en, input logic [4:0] idx, input logic [31:0] data);
    bus.wb_reg_wr_en   = en;
    bus.wb_reg_wr_idx  = idx;
    bus.wb_reg_wr_data = data;
  endtask

  initial begin
    // Reset held with arbitrary activity on the inputs
    rst = 1'b1;
    bus.ex_take_branch_out = 1'b0;
    fetch(32'h0000_0040, 32'h005303B3, 1'b1);
    wb(1'b1, 5'd5, 32'hAAAA_5555);
    tick();
    tick();
    chk("rst_ir",     bus.id_IR_out, 32'h00000013);
    chk("rst_valid",  {31'b0, bus.id_valid_inst_out}, 32'd0);
    chk("rst_rd",     {27'b0, bus.id_rd}, 32'd0);
    chk("rst_rs1",    bus.id_rs1_value, 32'd0);
    chk("rst_imm",    bus.id_imm, 32'd0);
    chk("rst_wr_en",  {31'b0, bus.id_reg_wr_en}, 32'd0);
    chk("rst_ill",    {31'b0, bus.id_illegal}, 32'd0);
    chk("rst_pc",     bus.id_PC_out, 32'd0);

    // Write x5, then read it through addi x6,x5,0
    rst = 1'b0;
    fetch(32'h0, 32'h00000013, 1'b0);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    fetch(32'h0000_0100, 32'h00028313, 1'b1);
    tick();
    chk("wr_rs1",    bus.id_rs1_value, 32'hDEADBEEF);
    chk("wr_rd",     {27'b0, bus.id_rd}, 32'd6);
    chk("wr_imm",    bus.id_imm, 32'd0);
    chk("wr_wr_en",  {31'b0, bus.id_reg_wr_en}, 32'd1);
    chk("wr_pc",     bus.id_PC_out, 32'h0000_0100);
    chk("wr_npc",    bus.id_NPC_out, 32'h0000_0104);
    chk("wr_valid",  {31'b0, bus.id_valid_inst_out}, 32'd1);

    // Same-cycle bypass on rs1 of add x7,x6,x5
    fetch(32'h0000_0104, 32'h005303B3, 1'b1);
    tick();
    wb(1'b1, 5'd6, 32'h12345678);
    #1;
    chk("byp_rs1",   bus.id_rs1_value, 32'h12345678);
    chk("byp_rs2",   bus.id_rs2_value, 32'hDEADBEEF);
    chk("byp_rd",    {27'b0, bus.id_rd}, 32'd7);

    // x0 write is never forwarded
    fetch(32'h0000_0108, 32'h00000013, 1'b1);
    tick();
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    chk("x0_rs1",    bus.id_rs1_value, 32'd0);
    chk("x0_rs2",    bus.id_rs2_value, 32'd0);

    // Flush squashes the instruction but PC still loads
    wb(1'b0, 5'd0, 32'h0);
    bus.ex_take_branch_out = 1'b1;
    fetch(32'h0000_0200, 32'h00028313, 1'b1);
    tick();
    chk("fl_ir",     bus.id_IR_out, 32'h00000013);
    chk("fl_valid",  {31'b0, bus.id_valid_inst_out}, 32'd0);
    chk("fl_rd",     {27'b0, bus.id_rd}, 32'd0);
    chk("fl_pc",     bus.id_PC_out, 32'h0000_0200);
    bus.ex_take_branch_out = 1'b0;

    // Stored x6 value and x5 both readable
    fetch(32'h0000_0204, 32'h005303B3, 1'b1);
    tick();
    chk("rf_rs1",    bus.id_rs1_value, 32'h12345678);
    chk("rf_rs2",    bus.id_rs2_value, 32'hDEADBEEF);

    // Immediate forms
    fetch(32'h0000_0208, 32'hFE000EE3, 1'b1);
    tick();
    chk("b_imm",     bus.id_imm, 32'hFFFFFFFC);
    chk("b_rd",      {27'b0, bus.id_rd}, 32'd0);
    chk("b_wr_en",   {31'b0, bus.id_reg_wr_en}, 32'd0);
    fetch(32'h0000_020C, 32'h123450B7, 1'b1);
    tick();
    chk("lui_imm",   bus.id_imm, 32'h12345000);
    chk("lui_rd",    {27'b0, bus.id_rd}, 32'd1);
    fetch(32'h0000_0210, 32'hFFDFF0EF, 1'b1);
    tick();
    chk("jal_imm",   bus.id_imm, 32'hFFFFFFFC);
    chk("jal_rd",    {27'b0, bus.id_rd}, 32'd1);
    fetch(32'h0000_0214, 32'hFFF00093, 1'b1);
    tick();
    chk("i_imm",     bus.id_imm, 32'hFFFFFFFF);

    // Illegal opcode, valid then invalid
    fetch(32'h0000_0218, 32'h0000007F, 1'b1);
    tick();
    chk("ill_v1",    {31'b0, bus.id_illegal}, 32'd1);
    chk("ill_rd",    {27'b0, bus.id_rd}, 32'd0);
    chk("ill_imm",   bus.id_imm, 32'd0);
    fetch(32'h0000_021C, 32'h0000007F, 1'b0);
    tick();
    chk("ill_v0",    {31'b0, bus.id_illegal}, 32'd0);

    // Reset wins over a simultaneous write-back
    rst = 1'b1;
    wb(1'b1, 5'd5, 32'h0000_0055);
    tick();
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    fetch(32'h0000_0300, 32'h00028313, 1'b1);
    tick();
    chk("rstpri_rs1", bus.id_rs1_value, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
